// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: the issue side (in_*, op1, op2, aluSel) and
// the result side (out_*, aluOut, illegal). master = issuer/consumer, slave = ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [3:0]       aluSel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] aluOut;
  logic             illegal;

  modport master (
    output in_valid, op1, op2, aluSel, out_ready,
    input  in_ready, out_valid, aluOut, illegal
  );

  modport slave (
    input  in_valid, op1, op2, aluSel, out_ready,
    output in_ready, out_valid, aluOut, illegal
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked RV32-style ALU with a registered result stage and WIDTH-bit datapath.
// Define ALU_PIPE_MUL_EN to add the iterative MUL/MULHU (opcodes 11/12).
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_pipe_if.slave io
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FULL = 2'd1
`ifdef ALU_PIPE_MUL_EN
    ,
    S_BUSY = 2'd2
`endif
  } state_t;

  // Single-cycle opcodes; returns {illegal, result}.
  function automatic logic [WIDTH:0] alu_eval(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [3:0]       sel);
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic        [SHW-1:0]   sh;
    logic        [WIDTH-1:0] r;
    logic                    ill;
    a_s = a;
    b_s = b;
    sh  = b[SHW-1:0];
    r   = '0;
    ill = 1'b0;
    case (sel)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      4'd6:    r = {{(WIDTH-1){1'b0}}, (a < b)};
      4'd7:    r = a << sh;
      4'd8:    r = a >> sh;
      4'd9:    r = a_s >>> sh;
      4'd10:   r = a;
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  state_t           state_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] res_p1;
  logic             ill_p1;
  logic             in_ready;
  logic             accept_p0;
  logic [WIDTH:0]   eval_p0;

  assign in_ready     = !rst && ((state_p1 == S_IDLE) ||
                                 ((state_p1 == S_FULL) && io.out_ready));
  assign io.in_ready  = in_ready;
  assign io.out_valid = vld_p1;
  assign io.aluOut    = res_p1;
  assign io.illegal   = ill_p1;

  assign accept_p0 = io.in_valid && in_ready;
  assign eval_p0   = alu_eval(io.op1, io.op2, io.aluSel);

`ifdef ALU_PIPE_MUL_EN
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand_p1;
  logic [WIDTH-1:0]   mplier_p1;
  logic [2*WIDTH-1:0] acc_p1;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     sum;
  logic               hi_p1;
  logic [SHW-1:0]     cnt_p1;
  logic               start_mul_p0;

  assign start_mul_p0 = accept_p0 && ((io.aluSel == 4'd11) || (io.aluSel == 4'd12));

  // Shift-add step: the carry out of the upper half becomes the new MSB.
  always_comb begin
    sum     = {1'b0, acc_p1[2*WIDTH-1:WIDTH]} + (mplier_p1[0] ? {1'b0, mcand_p1} : '0);
    acc_nxt = {sum, acc_p1[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (start_mul_p0) begin
      mcand_p1  <= io.op1;
      mplier_p1 <= io.op2;
      acc_p1    <= '0;
      hi_p1     <= (io.aluSel == 4'd12);
    end else if (state_p1 == S_BUSY) begin
      acc_p1    <= acc_nxt;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end
`endif

  // p0 -> p1: issue into the result register or the multiplier
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= S_IDLE;
      vld_p1   <= 1'b0;
      res_p1   <= '0;
      ill_p1   <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      cnt_p1   <= '0;
`endif
    end else begin
      case (state_p1)
        S_IDLE, S_FULL: begin
          if (accept_p0) begin
`ifdef ALU_PIPE_MUL_EN
            if (start_mul_p0) begin
              state_p1 <= S_BUSY;
              vld_p1   <= 1'b0;
              cnt_p1   <= '0;
            end else
`endif
            begin
              state_p1 <= S_FULL;
              vld_p1   <= 1'b1;
              res_p1   <= eval_p0[WIDTH-1:0];
              ill_p1   <= eval_p0[WIDTH];
            end
          end else if ((state_p1 == S_FULL) && io.out_ready) begin
            state_p1 <= S_IDLE;
            vld_p1   <= 1'b0;
          end
        end
`ifdef ALU_PIPE_MUL_EN
        S_BUSY: begin
          cnt_p1 <= cnt_p1 + 1'b1;
          if (cnt_p1 == CNT_LAST) begin
            state_p1 <= S_FULL;
            vld_p1   <= 1'b1;
            ill_p1   <= 1'b0;
            res_p1   <= hi_p1 ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
          end
        end
`endif
        default: begin
          state_p1 <= S_IDLE;
          vld_p1   <= 1'b0;
        end
      endcase
    end
  end
endmodule
